mem_bus_arbiter: RTL and testbench
==================================

// Module: mem_bus_arbiter
// PURPOSE
//  Shares the single synchronous memory bus between the 6502 core (CPU port) and a
//  secondary master (DMA/video port). Runs in the mem_clk domain, downstream of the
//  clock/reset generator. Grants one transaction at a time through a req/ack handshake.
//  Fixed CPU priority plus a DMA anti-starvation counter.
// PARAMETERS
//  ADDR_W        16  address width, both ports and memory
//  DATA_W        8   data width
//  MEM_WAIT      1   extra ACCESS cycles beyond the first (0..15); memory read latency
//  STARVE_LIMIT  4   consecutive CPU grants while DMA waits before DMA is forced (1..255)
// PORTS
//  clk          in   1       memory clock; all logic on posedge
//  reset        in   1       synchronous, active-high
//  cpu_req      in   1       CPU request; held until cpu_ack
//  cpu_we       in   1       1=write, 0=read
//  cpu_addr     in   ADDR_W  CPU address
//  cpu_wdata    in   DATA_W  CPU write data
//  cpu_rdata    out  DATA_W  read data; valid while cpu_ack=1, held until next CPU read
//  cpu_ack      out  1       one-cycle completion pulse
//  dma_req/we/addr/wdata/rdata/ack  same as cpu_* for the DMA port
//  mem_en       out  1       memory cycle active
//  mem_we       out  1       memory write strobe
//  mem_addr     out  ADDR_W  registered address
//  mem_wdata    out  DATA_W  registered write data
//  mem_rdata    in   DATA_W  memory read data, sampled on last ACCESS cycle
//  owner        out  1       0=CPU, 1=DMA; owner of current/last grant
//  busy         out  1       1 in ACCESS or ACK
// BEHAVIOUR
//  - reset: all outputs 0, state IDLE, starve counter 0; in-flight transfer aborted, no ack.
//  - FSM IDLE -> ACCESS -> ACK -> IDLE; all outputs registered.
//  - IDLE: if any req, pick winner, latch owner/addr/wdata/we into mem_* regs,
//    cnt<=MEM_WAIT, go ACCESS. No req: stay, mem_en=0.
//  - Winner: DMA if dma_req && (!cpu_req || starve==STARVE_LIMIT); else CPU.
//  - starve: +1 when CPU granted while dma_req=1 (saturates at STARVE_LIMIT);
//    cleared to 0 on DMA grant; unchanged otherwise.
//  - ACCESS: mem_en=1, mem_we=latched we; cnt==0 -> capture mem_rdata into owner's rdata
//    (reads only), go ACK; else cnt<=cnt-1. Duration MEM_WAIT+1 cycles.
//  - ACK: mem_en=0, mem_we=0, owner's ack=1 for exactly one cycle; next IDLE.
//  - Latency: req sampled at edge N -> mem_en high from N+1 -> ack high in cycle
//    N+MEM_WAIT+2. Back-to-back throughput: one transfer per MEM_WAIT+3 cycles.
//  - Handshake: requester drops req on the edge that samples ack=1; req still high in
//    IDLE is a new request. Changing addr/we/wdata after grant has no effect.
//  - Simultaneous cpu_req & dma_req in IDLE: CPU wins unless the starve rule applies.
//  - Non-owner ack stays 0; non-owner rdata unchanged.
//  - Writes leave both rdata regs unchanged.
// CONFIGURATION
//  MEM_ARB_RR_EN defined: strict round-robin; on a tie the port not granted last wins
//    (after reset CPU counts as last, so DMA wins the first tie); starve counter removed,
//    STARVE_LIMIT ignored.
//  MEM_ARB_RR_EN undefined: fixed CPU priority with starve rule above.
// TESTING
//  1. CPU read 0x1234, MEM_WAIT=1, mem_rdata=0xA5 -> mem_en 2 cycles, cpu_ack in cycle N+3, cpu_rdata=0xA5.
//  2. DMA write 0x8000=0x3C -> mem_we=1, mem_addr=0x8000, mem_wdata=0x3C for 2 cycles, dma_ack 1 pulse.
//  3. cpu_req & dma_req held continuously -> grant order C,C,C,C,D,C,C,C,C,D (STARVE_LIMIT=4).
//  4. Same stimulus with MEM_ARB_RR_EN -> D,C,D,C...; a lone req is granted immediately.
//  5. reset asserted in 1st ACCESS cycle -> next cycle mem_en=0, busy=0, no ack; fresh req completes normally.
//  6. MEM_WAIT=0, req kept high after ack -> second transfer starts; ack period 3 cycles.

Source files
------------

// File: rtl/mem_bus_arbiter_if.sv
// mem_bus_arbiter_if: CPU port, DMA port and memory-side signals of the shared memory bus.
// The slave modport is the arbiter's view; the master modport is the requesters' and memory's view.
interface mem_bus_arbiter_if #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 8
) ();

    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_ack;

    logic              dma_req;
    logic              dma_we;
    logic [ADDR_W-1:0] dma_addr;
    logic [DATA_W-1:0] dma_wdata;
    logic [DATA_W-1:0] dma_rdata;
    logic              dma_ack;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              owner;
    logic              busy;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_ack,
        input  dma_req, dma_we, dma_addr, dma_wdata,
        output dma_rdata, dma_ack,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata,
        output owner, busy
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_ack,
        output dma_req, dma_we, dma_addr, dma_wdata,
        input  dma_rdata, dma_ack,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata,
        input  owner, busy
    );

endinterface

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: grants the single memory bus to the CPU or DMA port one transfer at a time.
// Define MEM_ARB_RR_EN for round-robin arbitration instead of CPU priority with a DMA starve guard.
module mem_bus_arbiter #(
    parameter int unsigned ADDR_W       = 16,
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned MEM_WAIT     = 1,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input logic              clk,
    input logic              reset,
    mem_bus_arbiter_if.slave bus
);

    localparam int unsigned CNT_W = 4;
    localparam int unsigned STV_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_ACK    = 2'd2
    } state_e;

    state_e            state_q,     state_d;
    logic [CNT_W-1:0]  cnt_q,       cnt_d;
    logic              owner_q,     owner_d;
    logic              busy_q,      busy_d;
    logic              mem_en_q,    mem_en_d;
    logic              mem_we_q,    mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0] dma_rdata_q, dma_rdata_d;
    logic              cpu_ack_q,   cpu_ack_d;
    logic              dma_ack_q,   dma_ack_d;
    logic              any_req_c;
    logic              dma_win_c;

`ifdef MEM_ARB_RR_EN
    // Port granted most recently; reset value 0 makes the DMA port win the first tie.
    logic last_q, last_d;

    always_comb begin
        if (bus.cpu_req && bus.dma_req) begin
            dma_win_c = ~last_q;
        end else begin
            dma_win_c = bus.dma_req;
        end
    end
`else
    logic [STV_W-1:0] starve_q, starve_d;

    // CPU has priority unless the DMA port has waited through STARVE_LIMIT CPU grants.
    always_comb begin
        dma_win_c = bus.dma_req && (!bus.cpu_req || (starve_q == STV_W'(STARVE_LIMIT)));
    end
`endif

    assign any_req_c = bus.cpu_req || bus.dma_req;

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        owner_d     = owner_q;
        busy_d      = busy_q;
        mem_en_d    = mem_en_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cpu_rdata_d = cpu_rdata_q;
        dma_rdata_d = dma_rdata_q;
        cpu_ack_d   = 1'b0;
        dma_ack_d   = 1'b0;
`ifdef MEM_ARB_RR_EN
        last_d      = last_q;
`else
        starve_d    = starve_q;
`endif

        unique case (state_q)
            ST_IDLE: begin
                if (any_req_c) begin
                    state_d  = ST_ACCESS;
                    cnt_d    = CNT_W'(MEM_WAIT);
                    owner_d  = dma_win_c;
                    busy_d   = 1'b1;
                    mem_en_d = 1'b1;
                    if (dma_win_c) begin
                        mem_we_d    = bus.dma_we;
                        mem_addr_d  = bus.dma_addr;
                        mem_wdata_d = bus.dma_wdata;
                    end else begin
                        mem_we_d    = bus.cpu_we;
                        mem_addr_d  = bus.cpu_addr;
                        mem_wdata_d = bus.cpu_wdata;
                    end
`ifdef MEM_ARB_RR_EN
                    last_d = dma_win_c;
`else
                    if (dma_win_c) begin
                        starve_d = '0;
                    end else if (bus.dma_req && (starve_q != STV_W'(STARVE_LIMIT))) begin
                        starve_d = starve_q + STV_W'(1);
                    end
`endif
                end
            end

            ST_ACCESS: begin
                if (cnt_q == '0) begin
                    state_d  = ST_ACK;
                    mem_en_d = 1'b0;
                    mem_we_d = 1'b0;
                    // Read data is taken on the final access cycle, only by the owner.
                    if (!mem_we_q) begin
                        if (owner_q) begin
                            dma_rdata_d = bus.mem_rdata;
                        end else begin
                            cpu_rdata_d = bus.mem_rdata;
                        end
                    end
                    if (owner_q) begin
                        dma_ack_d = 1'b1;
                    end else begin
                        cpu_ack_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            ST_ACK: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end

            default: begin
                state_d  = ST_IDLE;
                busy_d   = 1'b0;
                mem_en_d = 1'b0;
                mem_we_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any transfer in flight without an ack.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            owner_q     <= 1'b0;
            busy_q      <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
            cpu_ack_q   <= 1'b0;
            dma_ack_q   <= 1'b0;
`ifdef MEM_ARB_RR_EN
            last_q      <= 1'b0;
`else
            starve_q    <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            owner_q     <= owner_d;
            busy_q      <= busy_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_rdata_q <= cpu_rdata_d;
            dma_rdata_q <= dma_rdata_d;
            cpu_ack_q   <= cpu_ack_d;
            dma_ack_q   <= dma_ack_d;
`ifdef MEM_ARB_RR_EN
            last_q      <= last_d;
`else
            starve_q    <= starve_d;
`endif
        end
    end

    assign bus.cpu_rdata = cpu_rdata_q;
    assign bus.cpu_ack   = cpu_ack_q;
    assign bus.dma_rdata = dma_rdata_q;
    assign bus.dma_ack   = dma_ack_q;
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.owner     = owner_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
// A second instance with MEM_WAIT=0 covers back-to-back throughput.
module tb_mem_bus_arbiter;

    localparam int unsigned AW = 16;
    localparam int unsigned DW = 8;
    localparam int unsigned MW = 1;
    localparam int unsigned SL = 4;

    logic clk = 1'b0;
    logic reset;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus  ();
    mem_bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus0 ();

    mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_WAIT(MW), .STARVE_LIMIT(SL)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_WAIT(0), .STARVE_LIMIT(SL)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    // Memory stub: content is a fixed function of address, driven only while a cycle is active.
    function automatic logic [7:0] mem_f(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h83;
    endfunction

    assign bus.mem_rdata  = bus.mem_en  ? mem_f(bus.mem_addr)  : 8'h00;
    assign bus0.mem_rdata = bus0.mem_en ? mem_f(bus0.mem_addr) : 8'h00;

    task automatic idle_ports();
        bus.cpu_req  = 1'b0; bus.cpu_we  = 1'b0; bus.cpu_addr  = '0; bus.cpu_wdata  = '0;
        bus.dma_req  = 1'b0; bus.dma_we  = 1'b0; bus.dma_addr  = '0; bus.dma_wdata  = '0;
        bus0.cpu_req = 1'b0; bus0.cpu_we = 1'b0; bus0.cpu_addr = '0; bus0.cpu_wdata = '0;
        bus0.dma_req = 1'b0; bus0.dma_we = 1'b0; bus0.dma_addr = '0; bus0.dma_wdata = '0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        idle_ports();
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [45:0] got;
        logic [45:0] got0;
        apply_reset();
        got  = {bus.mem_en, bus.mem_we, bus.busy, bus.owner, bus.cpu_ack, bus.dma_ack,
                bus.mem_addr, bus.mem_wdata, bus.cpu_rdata, bus.dma_rdata};
        got0 = {bus0.mem_en, bus0.mem_we, bus0.busy, bus0.owner, bus0.cpu_ack, bus0.dma_ack,
                bus0.mem_addr, bus0.mem_wdata, bus0.cpu_rdata, bus0.dma_rdata};
        vectors++;
        if (got !== 46'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %h expected 0", got);
        end
        vectors++;
        if (got0 !== 46'd0) begin
            miscompares++;
            $display("FAIL reset_outputs_w0: got %h expected 0", got0);
        end
    endtask

    task automatic test_cpu_read();
        int en_cnt = 0;
        int ack_at = 0;
        int acks = 0;
        int dacks = 0;
        bus.cpu_we   = 1'b0;
        bus.cpu_addr = 16'h1234;
        bus.cpu_req  = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk); #1;
            if (bus.mem_en) en_cnt++;
            if (bus.dma_ack) dacks++;
            if (bus.cpu_ack) begin
                acks++;
                if (ack_at == 0) ack_at = i;
                bus.cpu_req = 1'b0;
            end
        end
        vectors++;
        if (en_cnt != int'(MW + 1)) begin
            miscompares++;
            $display("FAIL cpu_read_en_cycles: got %0d expected %0d", en_cnt, MW + 1);
        end
        vectors++;
        if (ack_at != int'(MW + 2) || acks != 1 || dacks != 0) begin
            miscompares++;
            $display("FAIL cpu_read_ack: at %0d count %0d dma %0d expected at %0d count 1 dma 0",
                     ack_at, acks, dacks, MW + 2);
        end
        vectors++;
        if (bus.cpu_rdata !== 8'hA5) begin
            miscompares++;
            $display("FAIL cpu_read_data: got %h expected a5", bus.cpu_rdata);
        end
    endtask

    task automatic test_dma_write();
        int wcnt = 0;
        int acks = 0;
        int cacks = 0;
        @(negedge clk);
        bus.dma_we    = 1'b1;
        bus.dma_addr  = 16'h8000;
        bus.dma_wdata = 8'h3C;
        bus.dma_req   = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk); #1;
            if (bus.mem_en && bus.mem_we && bus.mem_addr == 16'h8000 && bus.mem_wdata == 8'h3C) wcnt++;
            if (bus.cpu_ack) cacks++;
            if (bus.dma_ack) begin
                acks++;
                bus.dma_req = 1'b0;
            end
        end
        vectors++;
        if (wcnt != int'(MW + 1)) begin
            miscompares++;
            $display("FAIL dma_write_cycles: got %0d expected %0d", wcnt, MW + 1);
        end
        vectors++;
        if (acks != 1 || cacks != 0 || bus.owner !== 1'b1) begin
            miscompares++;
            $display("FAIL dma_write_ack: dma %0d cpu %0d owner %b expected 1 0 1", acks, cacks, bus.owner);
        end
        vectors++;
        if (bus.cpu_rdata !== 8'hA5 || bus.dma_rdata !== 8'h00) begin
            miscompares++;
            $display("FAIL dma_write_rdata_kept: cpu %h dma %h expected a5 00", bus.cpu_rdata, bus.dma_rdata);
        end
    endtask

    task automatic test_arbitration();
        logic        exp_d [10];
        int unsigned s = 0;
        logic        last = 1'b0;
        int          k = 0;
        for (int i = 0; i < 10; i++) begin
`ifdef MEM_ARB_RR_EN
            exp_d[i] = ~last;
            last = exp_d[i];
`else
            if (s == SL) begin exp_d[i] = 1'b1; s = 0; end
            else begin exp_d[i] = 1'b0; s++; end
`endif
        end
        apply_reset();
        bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0010;
        bus.dma_we = 1'b0; bus.dma_addr = 16'h0020;
        bus.cpu_req = 1'b1;
        bus.dma_req = 1'b1;
        for (int c = 0; c < 200 && k < 10; c++) begin
            @(posedge clk); #1;
            if (bus.cpu_ack || bus.dma_ack) begin
                vectors++;
                if ((bus.cpu_ack && bus.dma_ack) || (bus.dma_ack !== exp_d[k])) begin
                    miscompares++;
                    $display("FAIL grant_order[%0d]: cpu_ack %b dma_ack %b expected dma=%b",
                             k, bus.cpu_ack, bus.dma_ack, exp_d[k]);
                end
                k++;
                if (k == 10) begin
                    bus.cpu_req = 1'b0;
                    bus.dma_req = 1'b0;
                end
            end
        end
        vectors++;
        if (k != 10) begin
            miscompares++;
            $display("FAIL grant_order_timeout: got %0d grants expected 10", k);
        end
    endtask

    task automatic test_reset_mid();
        int acks = 0;
        int ack_at = 0;
        apply_reset();
        bus.cpu_we   = 1'b0;
        bus.cpu_addr = 16'h0042;
        bus.cpu_req  = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if (bus.mem_en !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_mid_started: mem_en %b expected 1", bus.mem_en);
        end
        @(negedge clk);
        reset = 1'b1;
        bus.cpu_req = 1'b0;
        @(posedge clk); #1;
        vectors++;
        if ({bus.mem_en, bus.mem_we, bus.busy, bus.cpu_ack, bus.dma_ack} !== 5'd0) begin
            miscompares++;
            $display("FAIL reset_mid_abort: en %b we %b busy %b acks %b%b expected all 0",
                     bus.mem_en, bus.mem_we, bus.busy, bus.cpu_ack, bus.dma_ack);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (bus.cpu_ack || bus.dma_ack) acks++;
        end
        vectors++;
        if (acks != 0) begin
            miscompares++;
            $display("FAIL reset_mid_no_ack: got %0d acks expected 0", acks);
        end
        @(negedge clk);
        bus.cpu_addr = 16'h00FF;
        bus.cpu_req  = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk); #1;
            if (bus.cpu_ack && ack_at == 0) begin
                ack_at = i;
                bus.cpu_req = 1'b0;
            end
        end
        vectors++;
        if (ack_at != int'(MW + 2) || bus.cpu_rdata !== mem_f(16'h00FF)) begin
            miscompares++;
            $display("FAIL reset_mid_fresh: ack at %0d data %h expected at %0d data %h",
                     ack_at, bus.cpu_rdata, MW + 2, mem_f(16'h00FF));
        end
    endtask

    task automatic test_back_to_back();
        int          ack_cyc [4];
        int          k = 0;
        logic [15:0] cur;
        apply_reset();
        cur = 16'($urandom);
        bus0.cpu_we   = 1'b0;
        bus0.cpu_addr = cur;
        bus0.cpu_req  = 1'b1;
        for (int i = 1; i <= 30 && k < 4; i++) begin
            @(posedge clk); #1;
            if (bus0.cpu_ack) begin
                ack_cyc[k] = i;
                vectors++;
                if (bus0.cpu_rdata !== mem_f(cur)) begin
                    miscompares++;
                    $display("FAIL b2b_data[%0d]: got %h expected %h", k, bus0.cpu_rdata, mem_f(cur));
                end
                k++;
                cur = 16'($urandom);
                bus0.cpu_addr = cur;
                if (k == 4) bus0.cpu_req = 1'b0;
            end
        end
        vectors++;
        if (k != 4) begin
            miscompares++;
            $display("FAIL b2b_timeout: got %0d acks expected 4", k);
        end else begin
            vectors++;
            if (ack_cyc[0] != 2 || ack_cyc[1] - ack_cyc[0] != 3 ||
                ack_cyc[2] - ack_cyc[1] != 3 || ack_cyc[3] - ack_cyc[2] != 3) begin
                miscompares++;
                $display("FAIL b2b_period: acks at %0d %0d %0d %0d expected 2 5 8 11",
                         ack_cyc[0], ack_cyc[1], ack_cyc[2], ack_cyc[3]);
            end
        end
    endtask

    // Transaction model: p counts cycles since the grant edge (0 = bus free).
    task automatic test_random(input int n);
        int unsigned p = 0;
        logic        m_owner = 1'b0;
        logic        m_we = 1'b0;
        logic [15:0] m_addr = '0;
        logic [7:0]  m_wdata = '0;
        logic [7:0]  e_crd = '0;
        logic [7:0]  e_drd = '0;
        logic        c_pend = 1'b0, d_pend = 1'b0, c_gnt = 1'b0, d_gnt = 1'b0, dwin;
        logic [5:0]  exp_ctl, got_ctl;
        logic        e_en;
`ifdef MEM_ARB_RR_EN
        logic        last = 1'b0;
`else
        int unsigned starve = 0;
`endif
        apply_reset();
        for (int cyc = 0; cyc < n; cyc++) begin
            @(negedge clk);
            if (p == MW + 2) begin
                if (m_owner) begin d_pend = 1'b0; d_gnt = 1'b0; end
                else begin c_pend = 1'b0; c_gnt = 1'b0; end
            end
            if (!c_pend) begin
                if ($urandom_range(0, 2) != 0) begin
                    c_pend = 1'b1;
                    bus.cpu_we = 1'($urandom); bus.cpu_addr = 16'($urandom); bus.cpu_wdata = 8'($urandom);
                end
            end else if (c_gnt) begin
                bus.cpu_we = 1'($urandom); bus.cpu_addr = 16'($urandom); bus.cpu_wdata = 8'($urandom);
            end
            if (!d_pend) begin
                if ($urandom_range(0, 2) != 0) begin
                    d_pend = 1'b1;
                    bus.dma_we = 1'($urandom); bus.dma_addr = 16'($urandom); bus.dma_wdata = 8'($urandom);
                end
            end else if (d_gnt) begin
                bus.dma_we = 1'($urandom); bus.dma_addr = 16'($urandom); bus.dma_wdata = 8'($urandom);
            end
            bus.cpu_req = c_pend;
            bus.dma_req = d_pend;

            if (p == 0) begin
                if (c_pend || d_pend) begin
`ifdef MEM_ARB_RR_EN
                    dwin = (c_pend && d_pend) ? ~last : d_pend;
                    last = dwin;
`else
                    dwin = d_pend && (!c_pend || starve == SL);
                    if (dwin) starve = 0;
                    else if (d_pend && starve < SL) starve++;
`endif
                    m_owner = dwin;
                    m_we    = dwin ? bus.dma_we    : bus.cpu_we;
                    m_addr  = dwin ? bus.dma_addr  : bus.cpu_addr;
                    m_wdata = dwin ? bus.dma_wdata : bus.cpu_wdata;
                    if (dwin) d_gnt = 1'b1; else c_gnt = 1'b1;
                    p = 1;
                end
            end else if (p == MW + 2) begin
                p = 0;
            end else begin
                p++;
            end
            if (p == MW + 2 && !m_we) begin
                if (m_owner) e_drd = mem_f(m_addr); else e_crd = mem_f(m_addr);
            end

            @(posedge clk); #1;
            e_en    = (p >= 1) && (p <= MW + 1);
            exp_ctl = {e_en, e_en && m_we, p != 0, m_owner, (p == MW + 2) && !m_owner, (p == MW + 2) && m_owner};
            got_ctl = {bus.mem_en, bus.mem_we, bus.busy, bus.owner, bus.cpu_ack, bus.dma_ack};
            vectors++;
            if (got_ctl !== exp_ctl) begin
                miscompares++;
                $display("FAIL rand_ctl@%0d: en/we/busy/owner/cack/dack got %b expected %b", cyc, got_ctl, exp_ctl);
            end
            vectors++;
            if (bus.mem_addr !== m_addr || bus.mem_wdata !== m_wdata) begin
                miscompares++;
                $display("FAIL rand_mem_bus@%0d: addr %h data %h expected %h %h",
                         cyc, bus.mem_addr, bus.mem_wdata, m_addr, m_wdata);
            end
            vectors++;
            if (bus.cpu_rdata !== e_crd || bus.dma_rdata !== e_drd) begin
                miscompares++;
                $display("FAIL rand_rdata@%0d: cpu %h dma %h expected %h %h",
                         cyc, bus.cpu_rdata, bus.dma_rdata, e_crd, e_drd);
            end
        end
        @(negedge clk);
        bus.cpu_req = 1'b0;
        bus.dma_req = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        idle_ports();
        test_reset();
        test_cpu_read();
        test_dma_write();
        test_arbitration();
        test_reset_mid();
        test_back_to_back();
        test_random(600);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
